// File: rtl/wishb_pkg.sv
// Shared Wishbone definitions: bus widths and the slave FSM state encoding.
package wishb_pkg;

    localparam int WB_ADDR_W = 26;
    localparam int WB_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_HOLD = 2'd3
    } wb_state_e;

endpackage

// File: rtl/wishb_slave_ram.sv
// Single-port synchronous RAM, read-first, registered read data.
module wishb_slave_ram #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/wishb_slave_mem.sv
// Wishbone classic slave in front of a word-addressed RAM, with programmable wait states
// and a post-ack hold state. Optional address decode error: define WISHB_SLAVE_ERR_EN.
//
// state | meaning
// IDLE  | waiting for cyc_i & stb_i; request is captured here
// WAIT  | counting down wait states; cyc_i low aborts
// RESP  | RAM access; ack/err registered at the closing edge
// HOLD  | ack visible; wait for master to drop stb_i or cyc_i
module wishb_slave_mem
    import wishb_pkg::*;
#(
    parameter int              ADDR_W      = WB_ADDR_W,
    parameter int              DATA_W      = WB_DATA_W,
    parameter int              DEPTH_LOG2  = 10,
    parameter int              WAIT_STATES = 1,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cyc_i,
    input  logic              stb_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] adr_i,
    input  logic [DATA_W-1:0] dat_i,
    output logic [DATA_W-1:0] dat_o,
    output logic              ack_o,
    output logic              err_o
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    wb_state_e             state_q, state_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic                  we_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [DATA_W-1:0]     wdat_q;
    logic                  dec_err_q;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [DATA_W-1:0]     dat_q, dat_d;

    logic                  req;
    logic                  capture;
    logic                  resp;
    logic                  dec_err_in;
    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [DATA_W-1:0]     ram_rdata;

    assign req     = cyc_i & stb_i;
    assign capture = (state_q == ST_IDLE) && req;
    assign resp    = (state_q == ST_RESP);

`ifdef WISHB_SLAVE_ERR_EN
    logic unused_adr;
    assign dec_err_in = (adr_i[ADDR_W-1:DEPTH_LOG2+2] != BASE_ADDR[ADDR_W-1:DEPTH_LOG2+2]);
    assign unused_adr = &{1'b0, adr_i[1:0]};
`else
    logic unused_adr;
    assign dec_err_in = 1'b0;
    assign unused_adr = &{1'b0, adr_i[ADDR_W-1:DEPTH_LOG2+2], adr_i[1:0]};
`endif

    // Address the RAM with the live bus address in IDLE so read data is ready by RESP,
    // even with zero wait states.
    assign ram_addr = (state_q == ST_IDLE) ? adr_i[DEPTH_LOG2+1:2] : idx_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (req) state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
            ST_WAIT: begin
                if (!cyc_i) begin
                    state_d = ST_IDLE;
                end else if (wait_cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_HOLD;
            ST_HOLD: if (!stb_i || !cyc_i) state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (capture) begin
            wait_cnt_d = WAIT_INIT;
        end else if (state_q == ST_WAIT) begin
            wait_cnt_d = wait_cnt_q - 4'd1;
        end
        ack_d  = resp & ~dec_err_q;
        err_d  = resp & dec_err_q;
        ram_we = resp & we_q & ~dec_err_q & ~rst_i;
        dat_d  = (resp && !we_q && !dec_err_q) ? ram_rdata : dat_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt_q <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            dat_q      <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            dat_q      <= dat_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (capture) begin
            we_q      <= we_i;
            idx_q     <= adr_i[DEPTH_LOG2+1:2];
            wdat_q    <= dat_i;
            dec_err_q <= dec_err_in;
        end
    end

    wishb_slave_ram #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk_i),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdat_q),
        .rdata (ram_rdata)
    );

    assign dat_o = dat_q;
    assign ack_o = ack_q;
    assign err_o = err_q;

endmodule
